// File: rtl/iob_eth_mdio_pkg.sv
// iob_eth_mdio_pkg: shared types and constants for the MDIO controller.
// Clause-22 frame field values and the frame-builder helper live here.
package iob_eth_mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_TA,
    ST_DATA
  } mdio_state_e;

  localparam int         MDIO_PRE_LEN  = 32;
  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_RD    = 2'b10;
  localparam logic [1:0] MDIO_OP_WR    = 2'b01;
  localparam logic [1:0] MDIO_TA_WR    = 2'b10;
  localparam int         MDIO_DATA_LEN = 16;

  localparam logic [5:0] CNT_PRE  = 6'(MDIO_PRE_LEN - 1);
  localparam logic [5:0] CNT_CMD  = 6'd13;
  localparam logic [5:0] CNT_TA   = 6'd1;
  localparam logic [5:0] CNT_DATA = 6'(MDIO_DATA_LEN - 1);

  // Post-preamble part of the frame, MSB sent first.
  // Read frames park TA/DATA at 1 since the line is released there.
  function automatic logic [31:0] mdio_frame(
    input logic        rd,
    input logic [4:0]  phyad,
    input logic [4:0]  regad,
    input logic [15:0] wdata
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] dat;
    op  = rd ? MDIO_OP_RD : MDIO_OP_WR;
    ta  = rd ? 2'b11 : MDIO_TA_WR;
    dat = rd ? 16'hFFFF : wdata;
    return {MDIO_ST, op, phyad, regad, ta, dat};
  endfunction

endpackage

// File: rtl/iob_eth_mdio_clkgen.sv
// iob_eth_mdio_clkgen: MDC divider with end-of-half strobes.
// rise_tick = last low cycle, fall_tick = last high cycle.
module iob_eth_mdio_clkgen
  import iob_eth_mdio_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             mdc_o,
  output logic             fall_tick_o,
  output logic             rise_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             last;

  assign last        = (cnt_q == div_i - 1'b1);
  assign rise_tick_o = en_i & ~ph_q & last;
  assign fall_tick_o = en_i & ph_q & last;
  assign mdc_o       = ph_q;

  // Half-period counter; phase toggles at the end of each half.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr_i) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (en_i) begin
      if (last) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider state register, frozen when cke_i is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else if (cke_i) begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/iob_eth_mdio_ctrl.sv
// iob_eth_mdio_ctrl: clause-22 MDIO read/write frame sequencer.
// Optional IOB_ETH_MDIO_NOPRE_EN adds no_pre_i to skip the preamble.
module iob_eth_mdio_ctrl
  import iob_eth_mdio_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             start_i,
  input  logic             rd_i,
  input  logic [4:0]       phy_addr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [15:0]      wdata_i,
`ifdef IOB_ETH_MDIO_NOPRE_EN
  input  logic             no_pre_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      rdata_o,
  output logic             nack_o,
  output logic             mdc_o,
  output logic             mdio_o,
  output logic             mdio_oe_o,
  input  logic             mdio_i
);

  mdio_state_e      state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rd_q, rd_d;
  logic             ta_q, ta_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             skip_pre;
  logic             accept;
  logic             fall_tick;
  logic             rise_tick;
  logic             released;

`ifdef IOB_ETH_MDIO_NOPRE_EN
  assign skip_pre = no_pre_i;
`else
  assign skip_pre = 1'b0;
`endif

  assign accept   = (state_q == ST_IDLE) & start_i;
  assign busy_o   = (state_q != ST_IDLE);
  assign released = rd_q &
                    ((state_q == ST_TA) | (state_q == ST_DATA));

  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign nack_o    = nack_q;
  assign mdio_oe_o = busy_o & ~released;
  assign mdio_o    = ((state_q == ST_IDLE) | (state_q == ST_PRE))
                     ? 1'b1 : tx_q[31];

  iob_eth_mdio_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .cke_i      (cke_i),
    .en_i       (busy_o),
    .clr_i      (accept),
    .div_i      (div_q),
    .mdc_o      (mdc_o),
    .fall_tick_o(fall_tick),
    .rise_tick_o(rise_tick)
  );

  // Frame sequencer: bit counter counts down inside each field.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    div_d   = div_q;
    rd_d    = rd_q;
    ta_d    = ta_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rd_d  = rd_i;
          div_d = (div_i == '0) ? DIV_W'(1) : div_i;
          tx_d  = mdio_frame(rd_i, phy_addr_i,
                             reg_addr_i, wdata_i);
          if (skip_pre) begin
            state_d = ST_CMD;
            cnt_d   = CNT_CMD;
          end else begin
            state_d = ST_PRE;
            cnt_d   = CNT_PRE;
          end
        end
      end
      ST_PRE: begin
        if (fall_tick) begin
          if (cnt_q == '0) begin
            state_d = ST_CMD;
            cnt_d   = CNT_CMD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (fall_tick) begin
          tx_d = {tx_q[30:0], 1'b1};
          if (cnt_q == '0) begin
            state_d = ST_TA;
            cnt_d   = CNT_TA;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_TA: begin
        if (rise_tick && cnt_q == '0) begin
          ta_d = mdio_i;
        end
        if (fall_tick) begin
          tx_d = {tx_q[30:0], 1'b1};
          if (cnt_q == '0) begin
            state_d = ST_DATA;
            cnt_d   = CNT_DATA;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (rise_tick) begin
          rx_d = {rx_q[14:0], mdio_i};
        end
        if (fall_tick) begin
          tx_d = {tx_q[30:0], 1'b1};
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (rd_q) begin
              rdata_d = rx_q;
              nack_d  = ta_q;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state register, frozen when cke_i is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tx_q    <= '1;
      rx_q    <= '0;
      rdata_q <= '0;
      div_q   <= DIV_W'(1);
      rd_q    <= 1'b0;
      ta_q    <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      rd_q    <= rd_d;
      ta_q    <= ta_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_mdio_ctrl.sv
// tb_iob_eth_mdio_ctrl: timeline model of MDIO frames vs the DUT.
// Define IOB_ETH_MDIO_NOPRE_EN to exercise the preamble-skip build.
module tb_iob_eth_mdio_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cke = 1'b1;
  logic [7:0]  div = 8'd1;
  logic        start = 1'b0;
  logic        rd = 1'b0;
  logic [4:0]  phy = '0;
  logic [4:0]  rga = '0;
  logic [15:0] wdata = '0;
  logic        no_pre = 1'b0;
  logic        busy, done, nack, mdc, mdio, mdio_oe;
  logic [15:0] rdata;
  logic        mdio_in = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_eth_mdio_ctrl #(.DIV_W(8)) dut (
    .clk_i     (clk),
    .arst_n_i  (arst_n),
    .cke_i     (cke),
    .div_i     (div),
    .start_i   (start),
    .rd_i      (rd),
    .phy_addr_i(phy),
    .reg_addr_i(rga),
    .wdata_i   (wdata),
`ifdef IOB_ETH_MDIO_NOPRE_EN
    .no_pre_i  (no_pre),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .rdata_o   (rdata),
    .nack_o    (nack),
    .mdc_o     (mdc),
    .mdio_o    (mdio),
    .mdio_oe_o (mdio_oe),
    .mdio_i    (mdio_in)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a frame is N bits of 2D cycles from cycle 1; done at 1+2DN.
  bit          m_act = 0;
  int          m_t = 0;
  int          m_n = 64;
  int          m_d = 1;
  logic        m_rd = 0;
  logic [63:0] m_frame = '1;
  logic [15:0] m_rdata = '0;
  logic        m_nack = 0;
  bit          phy_on = 0;
  logic [15:0] phy_data = '0;

  function automatic int m_end();
    return 2 * m_d * m_n;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_act   <= 0;
      m_t     <= 0;
      m_rdata <= '0;
      m_nack  <= 0;
    end else if (start && !(m_act && m_t <= m_end())) begin
      m_act   <= 1;
      m_t     <= 1;
      m_rd    <= rd;
      m_d     <= (div == 0) ? 1 : int'(div);
      m_n     <= no_pre ? 32 : 64;
      m_frame <= {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01,
                  phy, rga, 2'b10, wdata};
    end else if (m_act) begin
      if (m_t == m_end() + 1) begin
        m_act <= 0;
      end else begin
        m_t <= m_t + 1;
        if (m_t == m_end() && m_rd) begin
          m_rdata <= phy_on ? phy_data : 16'hFFFF;
          m_nack  <= !phy_on;
        end
      end
    end
  end

  // PHY: TA = released (pull-up), 0, then data MSB first.
  always @(negedge clk) begin
    int b, tb;
    mdio_in = 1'b1;
    if (phy_on && m_act && m_rd && m_t <= m_end()) begin
      b  = (m_t - 1) / (2 * m_d);
      tb = m_n - 18;
      if (b == tb + 1) mdio_in = 1'b0;
      else if (b >= tb + 2) mdio_in = phy_data[15 - (b - tb - 2)];
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    logic e_busy, e_done, e_mdc, e_mdio, e_oe;
    int b, p;
    e_busy = 0; e_done = 0; e_mdc = 0; e_mdio = 1; e_oe = 0;
    if (m_act && m_t <= m_end()) begin
      b      = (m_t - 1) / (2 * m_d);
      p      = (m_t - 1) % (2 * m_d);
      e_busy = 1;
      e_mdc  = (p >= m_d);
      e_oe   = !m_rd || (b < m_n - 18);
      e_mdio = m_frame[m_n - 1 - b];
    end else if (m_act && m_t == m_end() + 1) begin
      e_done = 1;
    end
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("mdc", 64'(mdc), 64'(e_mdc));
    chk("mdio_oe", 64'(mdio_oe), 64'(e_oe));
    if (e_oe || !e_busy) chk("mdio", 64'(mdio), 64'(e_mdio));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("nack", 64'(nack), 64'(m_nack));
  end

  logic [63:0] cap = '0;
  always @(posedge mdc) cap <= {cap[62:0], mdio};

  task automatic run(input string nm, input logic r,
                     input logic [4:0] pa, input logic [4:0] ra,
                     input logic [15:0] wd, input logic [7:0] dv,
                     input logic np, input int exp_cyc,
                     input int restart_at);
    int n;
    @(negedge clk);
    rd = r; phy = pa; rga = ra; wdata = wd;
    div = dv; no_pre = np; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    div = dv + 8'd3;
    n = 1;
    while (!done && n < exp_cyc + 50) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
    end
    start = 1'b0;
    chk({nm, " done seen"}, 64'(done), 64'd1);
    chk({nm, " done cycle"}, 64'(n), 64'(exp_cyc));
  endtask

  initial begin
    int n;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst mdio", 64'(mdio), 64'd1);
    chk("rst oe", 64'(mdio_oe), 64'd0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("wr d4", 1'b0, 5'h01, 5'h00, 16'h8000, 8'd4, 1'b0, 513, 0);
    chk("wr stream", cap, 64'hFFFF_FFFF_5082_8000);

    phy_on = 1; phy_data = 16'h796D;
    run("rd d2", 1'b1, 5'h03, 5'h02, 16'h1234, 8'd2, 1'b0, 257, 0);
    chk("rd rdata", 64'(rdata), 64'h796D);
    chk("rd nack", 64'(nack), 64'd0);

    phy_on = 0;
    run("rd nophy", 1'b1, 5'h1F, 5'h11, 16'h0, 8'd2, 1'b0, 257, 0);
    chk("nophy rdata", 64'(rdata), 64'hFFFF);
    chk("nophy nack", 64'(nack), 64'd1);

    run("div0", 1'b0, 5'h0A, 5'h15, 16'hA5C3, 8'd0, 1'b0, 129, 50);
    chk("div0 rdata kept", 64'(rdata), 64'hFFFF);

    @(negedge clk);
    rd = 1'b0; phy = 5'h05; rga = 5'h06; wdata = 16'h0F0F;
    div = 8'd4; no_pre = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n < 300; n++) @(negedge clk);
    #1 arst_n = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst mdc", 64'(mdc), 64'd0);
    chk("arst mdio", 64'(mdio), 64'd1);
    chk("arst oe", 64'(mdio_oe), 64'd0);
    chk("arst rdata", 64'(rdata), 64'd0);
    chk("arst nack", 64'(nack), 64'd0);
    repeat (3) @(negedge clk);
    #1 arst_n = 1'b1;

    run("post rst", 1'b0, 5'h12, 5'h09, 16'h3C5A, 8'd1, 1'b0, 129, 0);
    chk("post rst stream", cap,
        {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h12, 5'h09, 2'b10, 16'h3C5A});

`ifdef IOB_ETH_MDIO_NOPRE_EN
    run("nopre", 1'b0, 5'h01, 5'h00, 16'h8000, 8'd4, 1'b1, 257, 0);
    chk("nopre stream", 64'(cap[31:0]), 64'h5082_8000);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
